gpr_mp: RTL and testbench

GPR_MP -- requirements
Module: gpr_mp

---
 rtl/gpr_mp_pkg.sv | 10 +
 rtl/gpr_mp_scoreboard.sv | 59 +++++
 rtl/gpr_mp.sv | 86 ++++++++
 tb/tb_gpr_mp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_mp_pkg.sv
// Shared constants for the multi-port general-purpose register file and its
// pending-write scoreboard.
package gpr_mp_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int FLAG_REG_DEF = 30;
    localparam int FLAG_BIT     = 0;

endpackage

// File: rtl/gpr_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by any
// enabled write, queried combinationally by every read port.
module gpr_scoreboard
    import gpr_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr0_en,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] q_addr,
    output logic [NUM_RD-1:0]        q_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    // Clear first, then set: a new producer issued in the same cycle as the
    // old producer's write must stay outstanding.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < DEPTH; i++) begin
            if ((clr0_en && clr0_addr == ADDR_W'(i)) ||
                (clr1_en && clr1_addr == ADDR_W'(i))) begin
                pending_next[i] = 1'b0;
            end
            if (set_en && set_addr == ADDR_W'(i)) begin
                pending_next[i] = 1'b1;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_query
        logic [ADDR_W-1:0] a;
        assign a = q_addr[k*ADDR_W +: ADDR_W];
        assign q_busy[k] = pending[a]
                         && !(clr0_en && clr0_addr == a)
                         && !(clr1_en && clr1_addr == a)
                         && (a != '0);
    end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port register file: NUM_RD write-through read ports, two write ports,
// overflow-flag overlay on FLAG_REG bit 0, and a pending-write scoreboard.
module gpr_mp
    import gpr_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int FLAG_REG = FLAG_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     of_wr_en,
    input  logic                     of_flag,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(FLAG_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr0_live;

    // An overflowing ALU result must not reach the register file.
    assign wr0_live = wr0_en && !(of_wr_en && of_flag);

    // Value register 'a' holds after the coming edge; shared by the array
    // update and the write-through read path so the two can never disagree.
    function automatic logic [DATA_W-1:0] next_val(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] v;
        v = cur;
        if (wr0_live && wr0_addr == a) v = wr0_data;
        if (wr1_en && wr1_addr == a)   v = wr1_data;
        if (of_wr_en && a == FLAG_ADDR) v[FLAG_BIT] = of_flag;
        if (a == '0) v = '0;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                regs[i] <= '0;
            end else begin
                regs[i] <= next_val(ADDR_W'(i), regs[i]);
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] val;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        always_comb begin
            val = next_val(a, regs[a]);
        end
        assign rd_data[k*DATA_W +: DATA_W] = val;
    end

    gpr_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_en),
        .set_addr  (iss_addr),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .q_addr    (rd_addr),
        .q_busy    (rd_busy)
    );

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: directed vector table with hand-derived expectations, a
// randomised phase checked against a behavioural model, and a reset sequence.
module tb_gpr_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int FLAG_REG = 30;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [ADDR_W-1:0]        ra0, ra1;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en, wr1_en, of_wr_en, of_flag, iss_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;

    assign rd_addr = {ra1, ra0};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    gpr_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .FLAG_REG (FLAG_REG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .of_wr_en (of_wr_en),
        .of_flag  (of_flag),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_regs [DEPTH];
    logic              m_pend [DEPTH];

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = m_regs[a];
        if (wr0_en && !(of_wr_en && of_flag) && wr0_addr == a) v = wr0_data;
        if (wr1_en && wr1_addr == a) v = wr1_data;
        if (of_wr_en && a == ADDR_W'(FLAG_REG)) v[0] = of_flag;
        if (a == '0) v = '0;
        return v;
    endfunction

    function automatic logic model_busy(input logic [ADDR_W-1:0] a);
        logic written;
        written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        return m_pend[a] && !written && (a != '0);
    endfunction

    function automatic void model_commit();
        logic [DATA_W-1:0] nv [DEPTH];
        logic              np [DEPTH];
        for (int a = 0; a < DEPTH; a++) begin
            nv[a] = model_rd(ADDR_W'(a));
            np[a] = m_pend[a];
            if ((wr0_en && wr0_addr == ADDR_W'(a)) || (wr1_en && wr1_addr == ADDR_W'(a)))
                np[a] = 1'b0;
            if (iss_en && iss_addr == ADDR_W'(a) && a != 0)
                np[a] = 1'b1;
            if (rst) begin
                nv[a] = '0;
                np[a] = 1'b0;
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            m_regs[a] = nv[a];
            m_pend[a] = np[a];
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [DATA_W:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DATA_W:0] act,
                         input logic [DATA_W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Push model expectations for both ports, let outputs settle, compare.
    task automatic settle_and_check();
        logic [DATA_W:0] e;
        exp_q.push_back({model_busy(ra0), model_rd(ra0)});
        exp_q.push_back({model_busy(ra1), model_rd(ra1)});
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            e = exp_q.pop_front();
            check($sformatf("sb_port%0d", k), {rd_busy[k], rd_data[k*DATA_W +: DATA_W]}, e);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        rst = 1'b0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        of_wr_en = 1'b0; of_flag = 1'b0;
        iss_en = 1'b0; iss_addr = '0;
        ra0 = '0; ra1 = '0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    typedef struct {
        logic              w0e;
        logic [ADDR_W-1:0] w0a;
        logic [DATA_W-1:0] w0d;
        logic              w1e;
        logic [ADDR_W-1:0] w1a;
        logic [DATA_W-1:0] w1d;
        logic              ofe;
        logic              ofv;
        logic              ise;
        logic [ADDR_W-1:0] isa;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] exp_d0;
        logic              exp_b0;
        logic [DATA_W-1:0] exp_d1;
    } vec_t;

    vec_t tbl[20];

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            m_regs[a] = '0;
            m_pend[a] = 1'b0;
        end
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        advance();
        advance();
        rst = 1'b0;

        //           w0e   w0a    w0d             w1e   w1a    w1d             ofe   ofv   ise   isa    a0     a1     d0              b0    d1
        tbl[0]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  32'h0,          1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'd5,  32'h1234,       1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd5,  5'd0,  32'h1234,       1'b0, 32'h0};
        tbl[2]  = '{1'b1, 5'd0,  32'hFFFF,       1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,          1'b0, 32'h1234};
        tbl[3]  = '{1'b1, 5'd7,  32'hAAAA,       1'b1, 5'd7,  32'h5555,       1'b0, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  32'h5555,       1'b0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  32'h5555,       1'b0, 32'h0};
        tbl[5]  = '{1'b1, 5'd3,  32'h77,         1'b0, 5'd0,  32'h0,          1'b1, 1'b1, 1'b0, 5'd0,  5'd3,  5'd30, 32'h0,          1'b0, 32'h1};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b0, 5'd0,  5'd3,  5'd30, 32'h0,          1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd30, 5'd3,  32'h0,          1'b0, 32'h0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd30, 32'hFFFFFFFE,   1'b1, 1'b1, 1'b0, 5'd0,  5'd30, 5'd5,  32'hFFFFFFFF,   1'b0, 32'h1234};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd30, 5'd0,  32'hFFFFFFFF,   1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b1, 5'd9,  5'd9,  5'd9,  32'h0,          1'b0, 32'h0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  5'd9,  32'h0,          1'b1, 32'h0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd9,  32'h42,         1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  5'd0,  32'h42,         1'b0, 32'h0};
        tbl[13] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  5'd0,  32'h42,         1'b0, 32'h0};
        tbl[14] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd9,  32'h43,         1'b0, 1'b0, 1'b1, 5'd9,  5'd9,  5'd0,  32'h43,         1'b0, 32'h0};
        tbl[15] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  5'd0,  32'h43,         1'b1, 32'h0};
        tbl[16] = '{1'b1, 5'd9,  32'h99,         1'b0, 5'd0,  32'h0,          1'b1, 1'b1, 1'b0, 5'd0,  5'd9,  5'd30, 32'h43,         1'b0, 32'hFFFFFFFF};
        tbl[17] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd9,  5'd30, 32'h43,         1'b0, 32'hFFFFFFFF};
        tbl[18] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,          1'b0, 32'h0};
        tbl[19] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,          1'b0, 32'h0};

        for (int i = 0; i < 20; i++) begin
            wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
            wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
            of_wr_en = tbl[i].ofe; of_flag = tbl[i].ofv;
            iss_en = tbl[i].ise; iss_addr = tbl[i].isa;
            ra0 = tbl[i].a0; ra1 = tbl[i].a1;
            settle_and_check();
            check($sformatf("tbl%0d_d0", i), {1'b0, rd_data[DATA_W-1:0]}, {1'b0, tbl[i].exp_d0});
            check($sformatf("tbl%0d_b0", i), {{DATA_W{1'b0}}, rd_busy[0]}, {{DATA_W{1'b0}}, tbl[i].exp_b0});
            check($sformatf("tbl%0d_d1", i), {1'b0, rd_data[2*DATA_W-1:DATA_W]}, {1'b0, tbl[i].exp_d1});
            advance();
        end

        // Randomised traffic with occasional reset, checked against the model.
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_addr = rnd_addr();
            wr0_data = $urandom;
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_addr = rnd_addr();
            wr1_data = $urandom;
            of_wr_en = ($urandom_range(0, 3) == 0);
            of_flag  = 1'($urandom_range(0, 1));
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = rnd_addr();
            ra0      = rnd_addr();
            ra1      = ($urandom_range(0, 3) == 0) ? ADDR_W'(FLAG_REG) : rnd_addr();
            settle_and_check();
            advance();
        end

        // Fill r1..r31, issue r4, then reset against concurrent traffic.
        set_idle();
        for (int a = 1; a < DEPTH; a++) begin
            wr0_en = 1'b1; wr0_addr = ADDR_W'(a); wr0_data = 32'hA000_0000 | 32'(a);
            iss_en = (a == DEPTH - 1); iss_addr = 5'd4;
            ra0 = ADDR_W'(a); ra1 = 5'd4;
            settle_and_check();
            advance();
        end
        set_idle();
        ra0 = 5'd4; ra1 = 5'd17;
        settle_and_check();
        check("fill_busy_r4", {{DATA_W{1'b0}}, rd_busy[0]}, {{DATA_W{1'b0}}, 1'b1});
        check("fill_data_r17", {1'b0, rd_data[2*DATA_W-1:DATA_W]}, {1'b0, 32'hA000_0011});
        advance();

        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h1111;
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h2222;
        of_wr_en = 1'b1; of_flag = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd10;
        ra0 = 5'd6; ra1 = 5'd4;
        settle_and_check();
        advance();

        set_idle();
        rst = 1'b1;
        ra0 = 5'd4; ra1 = 5'd10;
        settle_and_check();
        check("rst_hold_busy_r4", {{DATA_W{1'b0}}, rd_busy[0]}, '0);
        check("rst_hold_busy_r10", {{DATA_W{1'b0}}, rd_busy[1]}, '0);
        advance();

        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra0 = ADDR_W'(a); ra1 = ADDR_W'(DEPTH - 1 - a);
            settle_and_check();
            check($sformatf("post_rst_p0_r%0d", a), {rd_busy[0], rd_data[DATA_W-1:0]}, '0);
            check($sformatf("post_rst_p1_r%0d", DEPTH - 1 - a), {rd_busy[1], rd_data[2*DATA_W-1:DATA_W]}, '0);
            advance();
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
